// File: rtl/rram_phase_seq_vddl.sv
// ============================================================================
// Module  : rram_phase_seq_vddl
// Brief   : VDDL-domain read/write phase sequencer with programmable durations
// Revision: 1.0
// ============================================================================
`default_nettype none

module rram_phase_seq_vddl #(
    parameter int B_SIZE = 4,
    parameter int N_RD   = 2,
    parameter int CW     = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              op_i,
    input  logic              abort_i,
    input  logic              dummy_en_i,
    input  logic [CW-1:0]     t_pre_i,
    input  logic [CW-1:0]     t_dvlp_i,
    input  logic [CW-1:0]     t_sa_i,
    input  logic [CW-1:0]     t_wr_i,
    input  logic [B_SIZE-1:0] sa_data_i,
    output logic              write_vddl_o,
    output logic              not_write_vddl_o,
    output logic [N_RD-1:0]   read_vddl_o,
    output logic [N_RD-1:0]   not_read_vddl_o,
    output logic              pre_l_o,
    output logic              dvlp_l_o,
    output logic              sa_en_l_o,
    output logic              bus_oe_o,
    output logic [B_SIZE-1:0] rd_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_DVLP  = 3'd2,
        S_SENSE = 3'd3,
        S_WR    = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     t_dvlp_q, t_dvlp_d;
    logic [CW-1:0]     t_sa_q, t_sa_d;
    logic [B_SIZE-1:0] rd_data_q, rd_data_d;

    // A zero duration is treated as one cycle, so the counter loads max(T,1)-1.
    function automatic logic [CW-1:0] load_val(input logic [CW-1:0] t);
        return (t == '0) ? '0 : (t - CNT_ONE);
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            t_dvlp_q  <= '0;
            t_sa_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t_dvlp_q  <= t_dvlp_d;
            t_sa_q    <= t_sa_d;
            rd_data_q <= rd_data_d;
        end
    end

    // The first phase loads straight from the inputs; later phases use latched copies.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_dvlp_d  = t_dvlp_q;
        t_sa_d    = t_sa_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && dummy_en_i) begin
                    t_dvlp_d = t_dvlp_i;
                    t_sa_d   = t_sa_i;
                    if (op_i) begin
                        state_d = S_WR;
                        cnt_d   = load_val(t_wr_i);
                    end else begin
                        state_d = S_PRE;
                        cnt_d   = load_val(t_pre_i);
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_DVLP;
                    cnt_d   = load_val(t_dvlp_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DVLP: begin
                if (cnt_q == '0) begin
                    state_d = S_SENSE;
                    cnt_d   = load_val(t_sa_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SENSE: begin
                if (cnt_q == '0) begin
                    state_d   = S_FIN;
                    rd_data_d = sa_data_i;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WR: begin
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort outranks expiry and suppresses the capture.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            rd_data_d = rd_data_q;
        end
    end

    logic w_rd_act, w_wr_act;
    assign w_rd_act = (state_q == S_PRE) || (state_q == S_DVLP) || (state_q == S_SENSE);
    assign w_wr_act = (state_q == S_WR);

    assign read_vddl_o      = {N_RD{dummy_en_i &  w_rd_act}};
    assign not_read_vddl_o  = {N_RD{dummy_en_i & ~w_rd_act}};
    assign write_vddl_o     = dummy_en_i &  w_wr_act;
    assign not_write_vddl_o = dummy_en_i & ~w_wr_act;
    assign pre_l_o          = dummy_en_i & (state_q == S_PRE);
    assign dvlp_l_o         = dummy_en_i & (state_q == S_DVLP);
    assign sa_en_l_o        = dummy_en_i & (state_q == S_SENSE);
    assign bus_oe_o         = dummy_en_i & (state_q == S_SENSE);
    assign rd_data_o        = rd_data_q;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_rram_phase_seq_vddl.sv
// ============================================================================
// Module  : tb_rram_phase_seq_vddl
// Brief   : Directed bench; read data checked by a DONE-driven scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rram_phase_seq_vddl;

    localparam int B_SIZE = 4;
    localparam int N_RD   = 2;
    localparam int CW     = 4;

    // Phase codes used by the expected-output model.
    localparam int PI = 0, PP = 1, PD = 2, PS = 3, PW = 4, PF = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, op = 1'b0, abort = 1'b0, dummy_en = 1'b1;
    logic [CW-1:0]     t_pre = '0, t_dvlp = '0, t_sa = '0, t_wr = '0;
    logic [B_SIZE-1:0] sa_data = '0;
    logic              write_vddl, not_write_vddl, pre_l, dvlp_l, sa_en_l, bus_oe, busy, done;
    logic [N_RD-1:0]   read_vddl, not_read_vddl;
    logic [B_SIZE-1:0] rd_data;

    int n_chk  = 0;
    int n_pass = 0;
    logic [B_SIZE-1:0] sb_q[$];

    rram_phase_seq_vddl #(.B_SIZE(B_SIZE), .N_RD(N_RD), .CW(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op), .abort_i(abort),
        .dummy_en_i(dummy_en), .t_pre_i(t_pre), .t_dvlp_i(t_dvlp), .t_sa_i(t_sa),
        .t_wr_i(t_wr), .sa_data_i(sa_data), .write_vddl_o(write_vddl),
        .not_write_vddl_o(not_write_vddl), .read_vddl_o(read_vddl),
        .not_read_vddl_o(not_read_vddl), .pre_l_o(pre_l), .dvlp_l_o(dvlp_l),
        .sa_en_l_o(sa_en_l), .bus_oe_o(bus_oe), .rd_data_o(rd_data),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // {busy, done, wr, nwr, pre, dvlp, sa_en, oe, rd[1:0], nrd[1:0]}
    function automatic logic [11:0] exp_vec(input int ph, input logic de);
        logic ra;
        ra = (ph == PP) || (ph == PD) || (ph == PS);
        return {ph != PI, ph == PF, de && ph == PW, de && ph != PW,
                de && ph == PP, de && ph == PD, de && ph == PS, de && ph == PS,
                {2{de && ra}}, {2{de && !ra}}};
    endfunction

    function automatic logic [11:0] act_vec();
        return {busy, done, write_vddl, not_write_vddl, pre_l, dvlp_l,
                sa_en_l, bus_oe, read_vddl, not_read_vddl};
    endfunction

    task automatic step(input string nm, input int ph);
        @(negedge clk); #1;
        check(nm, 32'(act_vec()), 32'(exp_vec(ph, dummy_en)));
    endtask

    // Checks one IDLE cycle, then drives a START sampled on the next rising edge.
    task automatic issue(input string nm, input logic o, input logic [CW-1:0] tp,
                         input logic [CW-1:0] td, input logic [CW-1:0] ts,
                         input logic [CW-1:0] tw, input logic [B_SIZE-1:0] sd);
        step({nm, "_idle"}, PI);
        start = 1'b1; op = o; t_pre = tp; t_dvlp = td; t_sa = ts; t_wr = tw; sa_data = sd;
    endtask

    // Scoreboard monitor: every DONE pulse must match the oldest expected RD_DATA.
    always begin
        @(negedge clk); #1;
        if (rst_n && done) begin
            if (sb_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
            else check("done_rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_seq[$];
        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step("reset_outputs", PI);
        check("reset_rd_data", 32'(rd_data), 32'h0);

        // Read: PRE=2, DVLP=3, SA=1; START re-asserted in FIN must be ignored
        issue("read", 1'b0, 4'd2, 4'd3, 4'd1, 4'd0, 4'hA);
        sb_q.push_back(4'hA);
        rd_seq = '{PP, PP, PD, PD, PD, PS, PF};
        foreach (rd_seq[i]) begin
            step($sformatf("read_c%0d", i + 1), rd_seq[i]);
            start = (rd_seq[i] == PF);
        end
        step("read_c8_idle", PI);
        start = 1'b0;
        step("read_c9_idle", PI);

        // Zero-duration write
        issue("write0", 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'h3);
        sb_q.push_back(4'hA);
        step("write0_wr", PW);
        start = 1'b0;
        step("write0_fin", PF);
        step("write0_idle", PI);

        // Abort in DVLP together with a START that must not be taken
        issue("abort", 1'b0, 4'd1, 4'd3, 4'd1, 4'd0, 4'h5);
        step("abort_pre", PP);
        start = 1'b0;
        step("abort_dvlp", PD);
        abort = 1'b1; start = 1'b1;
        step("abort_idle1", PI);
        abort = 1'b0; start = 1'b0;
        step("abort_idle2", PI);
        check("abort_rd_data", 32'(rd_data), 32'hA);

        // DUMMY_EN dropped through SENSE and FIN
        issue("gate", 1'b0, 4'd1, 4'd1, 4'd2, 4'd0, 4'h3);
        sb_q.push_back(4'h3);
        step("gate_pre", PP);
        start = 1'b0;
        step("gate_dvlp", PD);
        dummy_en = 1'b0;
        step("gate_sense1", PS);
        step("gate_sense2", PS);
        step("gate_fin", PF);
        dummy_en = 1'b1;
        step("gate_idle", PI);
        dummy_en = 1'b0; start = 1'b1;
        step("gate_start_off1", PI);
        step("gate_start_off2", PI);
        start = 1'b0; dummy_en = 1'b1;
        step("gate_idle2", PI);

        // Asynchronous reset in the middle of a write
        issue("arst", 1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 4'h0);
        step("arst_wr1", PW);
        start = 1'b0;
        step("arst_wr2", PW);
        #2 rst_n = 1'b0;
        #1 check("arst_outputs", 32'(act_vec()), 32'(exp_vec(PI, dummy_en)));
        check("arst_rd_data", 32'(rd_data), 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;

        issue("post_rst_read", 1'b0, 4'd1, 4'd1, 4'd1, 4'd0, 4'hC);
        sb_q.push_back(4'hC);
        rd_seq = '{PP, PD, PS, PF, PI};
        foreach (rd_seq[i]) begin
            step($sformatf("post_rst_c%0d", i + 1), rd_seq[i]);
            start = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
